// File: rtl/ir_key_event_queue.sv
// Show-ahead event queue: registered head, occupancy count, pointers wrap modulo DEPTH.
// Latency: a push is visible at the head one edge later when the queue was empty.
// Backpressure: push_rdy drops when full unless a pop frees a slot on the same edge.
module ir_key_event_fifo #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              push_vld,
    input  logic [WIDTH-1:0]  push_dat,
    output logic              push_rdy,
    output logic              pop_vld,
    input  logic              pop_rdy,
    output logic [WIDTH-1:0]  pop_dat,
    output logic [ADDR_W:0]   count
);
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt_q;
    logic              full;
    logic              push;
    logic              pop;

    assign full     = (cnt_q == (ADDR_W+1)'(DEPTH));
    assign pop_vld  = (cnt_q != '0);
    assign pop      = pop_vld && pop_rdy;
    assign push_rdy = !full || pop;
    assign push     = push_vld && push_rdy;
    assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;
    assign count    = cnt_q;

    always_ff @(posedge iCLK) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (ADDR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (ADDR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// Validates IR frames, filters on custom code, tags new/hold-repeat keys and queues them.
// Latency: frame captured on the iDATA_READY edge, event reaches the queue head on the next edge.
// Backpressure: iREADY stalls the queue; events arriving at a full queue are dropped, oOVERFLOW sticks.
module ir_key_event_queue #(
    parameter logic [15:0] CUSTOM_CODE  = 16'h0000,
    parameter logic        FILTER_EN    = 1'b0,
    parameter logic        REPEAT_EN    = 1'b1,
    parameter int          HOLD_TIMEOUT = 6000000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          ADDR_W       = 3
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iDATA_READY,
    input  logic [31:0]       iDATA,
    output logic              oVALID,
    input  logic              iREADY,
    output logic [7:0]        oKEY,
    output logic              oREPEAT,
    output logic [ADDR_W:0]   oCOUNT,
    output logic              oHELD,
    output logic [7:0]        oLAST_KEY,
    output logic              oOVERFLOW,
    input  logic              iCLR_OVF,
    output logic [7:0]        oERR_CNT
);
    localparam int TIMER_W = $clog2(HOLD_TIMEOUT + 1);

    typedef struct packed {
        logic       rep;
        logic [7:0] key;
    } key_evt_t;

    typedef enum logic {IDLE, HELD} state_t;

    state_t             state;
    logic [31:0]        frame_q;
    logic               pend_q;
    logic [TIMER_W-1:0] timer_q;
    logic [7:0]         last_key_q;
    logic [7:0]         err_cnt_q;
    logic               ovf_q;

    logic [7:0]         key;
    logic               frame_ok;
    logic               push_vld;
    logic               push_rdy;
    key_evt_t           push_dat;
    key_evt_t           head;
    logic               drop;

    assign key      = frame_q[23:16];
    assign frame_ok = (frame_q[31:24] == ~key) &&
                      (!FILTER_EN || (frame_q[15:0] == CUSTOM_CODE));

    // A same-key frame while held is a hold-repeat; a new key while held is a fresh press.
    always_comb begin
        push_vld = 1'b0;
        push_dat = '0;
        push_dat.key = key;
        if (pend_q && frame_ok) begin
            if (state == IDLE) begin
                push_vld = 1'b1;
            end else if (key == last_key_q) begin
                push_vld     = REPEAT_EN;
                push_dat.rep = 1'b1;
            end else begin
                push_vld = 1'b1;
            end
        end
    end

    assign drop = push_vld && !push_rdy;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state      <= IDLE;
            frame_q    <= '0;
            pend_q     <= 1'b0;
            timer_q    <= '0;
            last_key_q <= '0;
            err_cnt_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            if (iDATA_READY) begin
                frame_q <= iDATA;
                pend_q  <= 1'b1;
            end else begin
                pend_q  <= 1'b0;
            end

            // An accepted frame beats a timer expiry on the same edge.
            if (pend_q && frame_ok) begin
                last_key_q <= key;
                timer_q    <= TIMER_W'(HOLD_TIMEOUT);
                state      <= HELD;
            end else begin
                if (pend_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_q <= err_cnt_q + 8'd1;
                end
                if (state == HELD) begin
                    if (timer_q == '0) begin
                        state <= IDLE;
                    end else begin
                        timer_q <= timer_q - TIMER_W'(1);
                    end
                end
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (iCLR_OVF) begin
                ovf_q <= 1'b0;
            end
        end
    end

    ir_key_event_fifo #(
        .WIDTH  ($bits(key_evt_t)),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .iCLK     (iCLK),
        .iRST_n   (iRST_n),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .push_rdy (push_rdy),
        .pop_vld  (oVALID),
        .pop_rdy  (iREADY),
        .pop_dat  (head),
        .count    (oCOUNT)
    );

    assign oKEY      = head.key;
    assign oREPEAT   = head.rep;
    assign oHELD     = (state == HELD);
    assign oLAST_KEY = last_key_q;
    assign oOVERFLOW = ovf_q;
    assign oERR_CNT  = err_cnt_q;
endmodule
